// File: rtl/uart_regs_mc_pkg.sv
// Shared address map, register layouts and sizing helpers for uart_regs_mc.
package uart_regs_mc_pkg;

    localparam logic [7:0] ADDR_CR      = 8'h00;
    localparam logic [7:0] ADDR_SR      = 8'h01;
    localparam logic [7:0] ADDR_PKCNT   = 8'h02;
    localparam logic [7:0] ADDR_IER     = 8'h03;
    localparam logic [7:0] ADDR_PK0     = 8'h08;
    localparam logic [7:0] ADDR_PKCH    = 8'h0B;
    localparam logic [7:0] ADDR_CH_BASE = 8'h10;
    localparam logic [2:0] OFF_CHCR     = 3'd4;
    localparam logic [2:0] OFF_CHSR     = 3'd5;

    typedef struct packed {
        logic       soft_rst;
        logic [3:0] rsvd;
        logic       fifo_flush;
        logic [1:0] src_sel;
    } cr_t;

    typedef struct packed {
        logic alg_any;
        logic pk_ovf;
        logic pk_full;
        logic pk_empty;
        logic rx_f;
        logic rx_e;
        logic tx_f;
        logic tx_e;
    } sr_t;

    typedef struct packed {
        logic [5:0] rsvd;
        logic       rst;
        logic       en;
    } chcr_t;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       alg_active;
        logic       th_inited;
        logic       ma_l;
        logic       ma_s;
    } chsr_t;

    // Sized for the widest supported counter; narrower builds zero-extend num.
    typedef struct packed {
        logic [2:0]  ch;
        logic [23:0] num;
    } peak_rec_t;

    function automatic int unsigned nb_bytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_regs_mc_peak_fifo.sv
// Synchronous FIFO with flush; a pop frees a slot for a same-cycle push when full.
module peak_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_regs_mc.sv
// Multi-channel UART register bank: sample injection, channel control/status, R-peak FIFO.
// Optional interrupt output enabled by defining UART_REGS_IRQ_EN.
module uart_regs_mc
    import uart_regs_mc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned CTR_WIDTH  = 22,
    parameter int unsigned PEAK_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [7:0]                   i_rwaddr,
    input  logic [7:0]                   i_write_data,
    input  logic                         i_wr_req,
    input  logic                         i_rd_req,
    input  logic                         i_peak_vld,
    input  logic [2:0]                   i_peak_ch,
    input  logic [CTR_WIDTH-1:0]         i_peak_num,
    input  logic [NUM_CH-1:0]            i_mas_valid,
    input  logic [NUM_CH-1:0]            i_mal_valid,
    input  logic [NUM_CH-1:0]            i_th_inited,
    input  logic [NUM_CH-1:0]            i_alg_active,
    input  logic                         i_tx_fifo_e,
    input  logic                         i_tx_fifo_f,
    input  logic                         i_rx_fifo_e,
    input  logic                         i_rx_fifo_f,
    output logic [7:0]                   o_read_data,
    output logic [NUM_CH*SAMPLE_W-1:0]   o_ecg_value,
    output logic [NUM_CH-1:0]            o_ecg_value_vld,
    output logic [NUM_CH-1:0]            o_alg_nrst,
    output logic [NUM_CH-1:0]            o_alg_en,
    output logic [1:0]                   o_src_sel,
    output logic                         o_irq
);
    localparam int unsigned NB    = nb_bytes(SAMPLE_W);
    localparam int unsigned NBP   = nb_bytes(CTR_WIDTH);
    localparam int unsigned REC_W = 3 + CTR_WIDTH;
    localparam int unsigned CNT_W = $clog2(PEAK_DEPTH) + 1;

    logic [1:0]                 r_src_sel;
    logic                       r_flush;
    logic                       r_soft_rst;
    sr_t                        r_sr;
    chsr_t                      r_chsr [NUM_CH];
    logic [NUM_CH-1:0]          r_ch_en;
    logic [NUM_CH-1:0]          r_ch_rst;
    logic [NB*8-1:0]            r_din [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0] r_ecg;
    logic [NUM_CH-1:0]          r_ecg_vld;
    peak_rec_t                  r_hold;
    logic                       r_pk_ovf;
    logic [7:0]                 r_read_data;

    logic [NB*8-1:0]            w_din_next [NUM_CH];
    logic [NUM_CH-1:0]          w_ch_sel;
    logic [NUM_CH-1:0]          w_commit;
    logic [4:0]                 w_ch_idx;
    logic [2:0]                 w_off;
    logic                       w_ch_hit;
    logic                       w_cr_wr;
    logic                       w_sr_rd;
    logic                       w_pk_push;
    logic                       w_pk_pop;
    logic                       w_pk_full;
    logic                       w_pk_empty;
    logic                       w_ovf_set;
    logic [REC_W-1:0]           w_pk_head;
    logic [CNT_W-1:0]           w_pk_count;
    peak_rec_t                  w_head_rec;
    logic [7:0]                 w_rd_byte;

    assign w_ch_idx  = i_rwaddr[7:3] - 5'd2;
    assign w_off     = i_rwaddr[2:0];
    assign w_ch_hit  = (i_rwaddr >= ADDR_CH_BASE) && (w_ch_idx < 5'(NUM_CH));
    assign w_cr_wr   = i_wr_req && (i_rwaddr == ADDR_CR);
    assign w_sr_rd   = i_rd_req && (i_rwaddr == ADDR_SR);
    assign w_pk_push = i_peak_vld && ({1'b0, i_peak_ch} < 4'(NUM_CH));
    assign w_pk_pop  = i_rd_req && (i_rwaddr == ADDR_PK0);
    // A full FIFO only overflows when no pop frees a slot and no flush discards the push.
    assign w_ovf_set = w_pk_push && w_pk_full && !(w_pk_pop && !w_pk_empty) && !r_flush;

    always_comb begin
        w_head_rec     = '0;
        w_head_rec.ch  = w_pk_head[REC_W-1 -: 3];
        w_head_rec.num = 24'(w_pk_head[CTR_WIDTH-1:0]);
    end

    always_comb begin
        w_ch_sel = '0;
        w_commit = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_ch_sel[c]   = w_ch_hit && (w_ch_idx == 5'(c));
            w_commit[c]   = i_wr_req && w_ch_sel[c] && (w_off == 3'(NB - 1));
            w_din_next[c] = r_din[c];
            for (int unsigned b = 0; b < NB; b++) begin
                if (i_wr_req && w_ch_sel[c] && (w_off == 3'(b)))
                    w_din_next[c][8*b +: 8] = i_write_data;
            end
        end
    end

    peak_fifo #(
        .WIDTH (REC_W),
        .DEPTH (PEAK_DEPTH)
    ) u_peak_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_pk_push),
        .i_data  ({i_peak_ch, i_peak_num}),
        .i_pop   (w_pk_pop),
        .i_flush (r_flush),
        .o_data  (w_pk_head),
        .o_full  (w_pk_full),
        .o_empty (w_pk_empty),
        .o_count (w_pk_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src_sel   <= '0;
            r_flush     <= 1'b0;
            r_soft_rst  <= 1'b0;
            r_sr        <= '0;
            r_pk_ovf    <= 1'b0;
            r_hold      <= '0;
            r_read_data <= '0;
        end else begin
            r_flush    <= w_cr_wr && i_write_data[2];
            r_soft_rst <= w_cr_wr && i_write_data[7];
            if (w_cr_wr) r_src_sel <= i_write_data[1:0];

            r_sr.tx_e     <= i_tx_fifo_e;
            r_sr.tx_f     <= i_tx_fifo_f;
            r_sr.rx_e     <= i_rx_fifo_e;
            r_sr.rx_f     <= i_rx_fifo_f;
            r_sr.pk_empty <= w_pk_empty;
            r_sr.pk_full  <= w_pk_full;
            r_sr.pk_ovf   <= r_pk_ovf;
            r_sr.alg_any  <= |i_alg_active;

            if (r_flush)        r_pk_ovf <= 1'b0;
            else if (w_ovf_set) r_pk_ovf <= 1'b1;
            else if (w_sr_rd)   r_pk_ovf <= 1'b0;

            if (w_pk_pop) r_hold <= w_pk_empty ? '0 : w_head_rec;
            if (i_rd_req) r_read_data <= w_rd_byte;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch_en   <= '0;
            r_ch_rst  <= '0;
            r_ecg     <= '0;
            r_ecg_vld <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_din[c]  <= '0;
                r_chsr[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_din[c]     <= w_din_next[c];
                r_ecg_vld[c] <= w_commit[c];
                if (w_commit[c]) r_ecg[c*SAMPLE_W +: SAMPLE_W] <= w_din_next[c][SAMPLE_W-1:0];
                r_ch_rst[c] <= i_wr_req && w_ch_sel[c] && (w_off == OFF_CHCR) && i_write_data[1];
                if (i_wr_req && w_ch_sel[c] && (w_off == OFF_CHCR)) r_ch_en[c] <= i_write_data[0];
                r_chsr[c]            <= '0;
                r_chsr[c].ma_s       <= i_mas_valid[c];
                r_chsr[c].ma_l       <= i_mal_valid[c];
                r_chsr[c].th_inited  <= i_th_inited[c];
                r_chsr[c].alg_active <= i_alg_active[c];
            end
        end
    end

`ifdef UART_REGS_IRQ_EN
    logic [7:0] r_ier;
    logic       r_irq;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ier <= '0;
            r_irq <= 1'b0;
        end else begin
            if (i_wr_req && (i_rwaddr == ADDR_IER)) r_ier <= i_write_data;
            r_irq <= |(r_ier[1:0] & {r_pk_ovf, !w_pk_empty});
        end
    end
    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

    // Read mux sees pre-write state, so a simultaneous write is invisible to this read.
    always_comb begin
        w_rd_byte = '0;
        case (i_rwaddr)
            ADDR_CR:    w_rd_byte = {r_soft_rst, 4'b0000, r_flush, r_src_sel};
            ADDR_SR:    w_rd_byte = r_sr;
            ADDR_PKCNT: w_rd_byte = 8'(w_pk_count);
            ADDR_PKCH:  w_rd_byte = {5'b00000, r_hold.ch};
`ifdef UART_REGS_IRQ_EN
            ADDR_IER:   w_rd_byte = r_ier;
`endif
            default:    w_rd_byte = '0;
        endcase
        for (int unsigned k = 0; k < NBP; k++) begin
            if (i_rwaddr == ADDR_PK0 + 8'(k))
                w_rd_byte = (k == 0) ? (w_pk_empty ? 8'h00 : w_head_rec.num[7:0])
                                     : r_hold.num[8*k +: 8];
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_ch_sel[c]) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (w_off == 3'(b)) w_rd_byte = r_din[c][8*b +: 8];
                end
                if (w_off == OFF_CHCR) w_rd_byte = {6'b000000, r_ch_rst[c], r_ch_en[c]};
                if (w_off == OFF_CHSR) w_rd_byte = r_chsr[c];
            end
        end
    end

    assign o_read_data     = r_read_data;
    assign o_ecg_value     = r_ecg;
    assign o_ecg_value_vld = r_ecg_vld;
    assign o_alg_nrst      = ~(r_ch_rst | {NUM_CH{r_soft_rst}});
    assign o_alg_en        = r_ch_en;
    assign o_src_sel       = r_src_sel;

endmodule
